// File: rtl/buffer_reader_if.sv
// buffer_reader_if
//   Output handshake of buffer_reader.
//   Signals:
//     out_valid  master -> slave  a word is presented on out_data/out_buf
//     out_ready  slave  -> master downstream can take the word
//     out_data   master -> slave  2-bit data of the emitted slot
//     out_buf    master -> slave  source buffer index (0 = buffer1 .. 3 = buffer4)
//   Handshake: a word transfers on a rising clk edge where out_valid and
//   out_ready are both high. Once out_valid rises it stays high, and
//   out_data/out_buf stay constant, until that transfer edge. out_ready may
//   toggle freely and has no effect while out_valid is low.
interface buffer_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic [1:0] out_buf;

    modport master (
        output out_valid,
        output out_data,
        output out_buf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_buf,
        output out_ready
    );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader
//   Reads four packed slot buffers (slot = {data[1:0], valid}) round-robin.
//   Each tick taken in IDLE scans at most one buffer head per cycle and
//   emits the first unread valid slot on the out_if handshake.
//   The producer never clears slots, so a per-slot "consumed" flag is kept
//   here and is re-armed whenever the slot content changes.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     tick               read request, only looked at in IDLE
//     buffer1_i..4_i     packed buffers, slot k at [ENTRY_W*k +: ENTRY_W]
//     out_if (master)    out_valid/out_ready/out_data/out_buf
//     out_count          accepted word count, saturating
//     busy               high while not IDLE
//     dbg_state          current FSM state (IDLE=0, SCAN=1, HOLD=2)
module buffer_reader #(
    parameter int DEPTH   = 6,
    parameter int ENTRY_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [DEPTH*ENTRY_W-1:0] buffer1_i,
    input  logic [DEPTH*ENTRY_W-1:0] buffer2_i,
    input  logic [DEPTH*ENTRY_W-1:0] buffer3_i,
    input  logic [DEPTH*ENTRY_W-1:0] buffer4_i,
    buffer_reader_if.master          out_if,
    output logic [CNT_W-1:0]         out_count,
    output logic                     busy,
    output logic [1:0]               dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BUF_W = DEPTH * ENTRY_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cur_buf_q, cur_buf_d;
    logic [1:0]       scan_cnt_q, scan_cnt_d;
    logic [PTR_W-1:0] rd_ptr_q [4];
    logic [PTR_W-1:0] rd_ptr_d [4];
    logic [DEPTH-1:0] consumed_q [4];
    logic [DEPTH-1:0] consumed_d [4];
    logic [BUF_W-1:0] prev_q [4];
    logic [BUF_W-1:0] prev_d [4];
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_data_q, out_data_d;
    logic [1:0]       out_buf_q, out_buf_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic [BUF_W-1:0]   bufs [4];
    logic [PTR_W-1:0]   cur_ptr;
    logic [ENTRY_W-1:0] head;
    logic               head_ready;

    assign bufs[0] = buffer1_i;
    assign bufs[1] = buffer2_i;
    assign bufs[2] = buffer3_i;
    assign bufs[3] = buffer4_i;

    assign cur_ptr    = rd_ptr_q[cur_buf_q];
    assign head       = bufs[cur_buf_q][ENTRY_W*cur_ptr +: ENTRY_W];
    assign head_ready = head[0] & ~consumed_q[cur_buf_q][cur_ptr];

    always_comb begin
        state_d     = state_q;
        cur_buf_d   = cur_buf_q;
        scan_cnt_d  = scan_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        consumed_d  = consumed_q;
        prev_d      = bufs;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_buf_d   = out_buf_q;
        out_count_d = out_count_q;

        // A changed slot is new content and becomes readable again.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (bufs[b][ENTRY_W*k +: ENTRY_W] != prev_q[b][ENTRY_W*k +: ENTRY_W]) begin
                    consumed_d[b][k] = 1'b0;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d    = SCAN;
                    scan_cnt_d = 2'd0;
                end
            end
            SCAN: begin
                cur_buf_d = cur_buf_q + 2'd1;
                if (head_ready) begin
                    // Written after the change loop: consuming the slot this
                    // cycle overrides a same-cycle re-arm, since the word
                    // being emitted is the new content.
                    consumed_d[cur_buf_q][cur_ptr] = 1'b1;
                    rd_ptr_d[cur_buf_q] = (cur_ptr == PTR_W'(DEPTH - 1)) ? '0 : cur_ptr + 1'b1;
                    out_data_d  = head[2:1];
                    out_buf_d   = cur_buf_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    scan_cnt_d = scan_cnt_q + 2'd1;
                    // Fourth empty head in a row: every buffer was looked at.
                    if (scan_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_count_q != {CNT_W{1'b1}}) begin
                        out_count_d = out_count_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_buf_q   <= 2'd0;
            scan_cnt_q  <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'd0;
            out_buf_q   <= 2'd0;
            out_count_q <= '0;
            for (int b = 0; b < 4; b++) begin
                rd_ptr_q[b]   <= '0;
                consumed_q[b] <= '0;
                prev_q[b]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_buf_q   <= cur_buf_d;
            scan_cnt_q  <= scan_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_buf_q   <= out_buf_d;
            out_count_q <= out_count_d;
            rd_ptr_q    <= rd_ptr_d;
            consumed_q  <= consumed_d;
            prev_q      <= prev_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_buf   = out_buf_q;
    assign out_count        = out_count_q;
    assign busy             = (state_q != IDLE);
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader
//   Directed bench for buffer_reader. The bench owns the buffer contents and
//   a transaction-level model (contents, consumed flags, read pointers,
//   round-robin start, accepted count). For each tick the model decides
//   which slot is served and after how many scan cycles, and the driver turns
//   that into per-cycle expected outputs checked on every falling edge.
module tb_buffer_reader;
    logic        clk;
    logic        rst;
    logic        tick;
    logic [17:0] buffer1_i, buffer2_i, buffer3_i, buffer4_i;
    logic [7:0]  out_count;
    logic        busy;
    logic [1:0]  dbg_state;

    buffer_reader_if bus ();

    buffer_reader dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .buffer1_i (buffer1_i),
        .buffer2_i (buffer2_i),
        .buffer3_i (buffer3_i),
        .buffer4_i (buffer4_i),
        .out_if    (bus),
        .out_count (out_count),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [2:0] m_buf [4][6];
    bit         m_cons [4][6];
    int         m_ptr [4];
    int         m_cur;
    int         m_count;

    // Per-cycle expectations
    logic       exp_valid;
    logic       exp_busy;
    logic [1:0] exp_data;
    logic [1:0] exp_buf;
    logic [7:0] exp_count;
    bit         check_en;

    logic [3:0] exp_q [$];   // {buf, data} of words expected to transfer
    logic [3:0] acc_q [$];   // {buf, data} of words seen transferring

    int n_checks;
    int n_errors;

    always_comb begin
        buffer1_i = '0;
        buffer2_i = '0;
        buffer3_i = '0;
        buffer4_i = '0;
        for (int k = 0; k < 6; k++) begin
            buffer1_i[3*k +: 3] = m_buf[0][k];
            buffer2_i[3*k +: 3] = m_buf[1][k];
            buffer3_i[3*k +: 3] = m_buf[2][k];
            buffer4_i[3*k +: 3] = m_buf[3][k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(exp_busy));
            chk("out_count", 32'(out_count), 32'(exp_count));
            if (exp_valid) begin
                chk("out_data", 32'(bus.out_data), 32'(exp_data));
                chk("out_buf", 32'(bus.out_buf), 32'(exp_buf));
            end
            if (bus.out_valid && bus.out_ready) begin
                acc_q.push_back({bus.out_buf, bus.out_data});
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", 32'd1, 32'd0);
                end else begin
                    chk("sb_word", 32'({bus.out_buf, bus.out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_ptr[b] = 0;
            for (int k = 0; k < 6; k++) m_cons[b][k] = 1'b0;
        end
        m_cur     = 0;
        m_count   = 0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_data  = 2'd0;
        exp_buf   = 2'd0;
        exp_count = 8'd0;
    endtask

    // Drivers (called #1 after a rising edge)
    task automatic set_slot(input int b, input int k, input logic [2:0] val);
        if (m_buf[b][k] != val) m_cons[b][k] = 1'b0;
        m_buf[b][k] = val;
    endtask

    task automatic clear_bufs();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 6; k++) set_slot(b, k, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One read request. hold_cycles: cycles with out_ready low (ticks pulsed
    // meanwhile); abort: reset instead of accepting the word.
    task automatic issue_tick(input int hold_cycles, input bit abort);
        bit found;
        int n, fb, fk;
        found = 1'b0;
        n  = 4;
        fb = 0;
        fk = 0;
        for (int i = 0; i < 4; i++) begin
            int b;
            b = (m_cur + i) % 4;
            if (!found && m_buf[b][m_ptr[b]][0] && !m_cons[b][m_ptr[b]]) begin
                found = 1'b1;
                n  = i + 1;
                fb = b;
                fk = m_ptr[b];
            end
        end
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        exp_busy = 1'b1;
        repeat (n - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!found) begin
            exp_busy = 1'b0;
        end else begin
            m_cons[fb][fk] = 1'b1;
            m_ptr[fb] = (fk + 1) % 6;
            m_cur = (fb + 1) % 4;
            exp_valid = 1'b1;
            exp_data  = m_buf[fb][fk][2:1];
            exp_buf   = fb[1:0];
            for (int c = 0; c < hold_cycles; c++) begin
                tick = (c % 2 == 0);
                @(posedge clk); #1;
            end
            tick = 1'b0;
            if (abort) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
            end else begin
                exp_q.push_back({exp_buf, exp_data});
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                exp_valid = 1'b0;
                exp_busy  = 1'b0;
                if (m_count < 255) m_count++;
                exp_count = 8'(m_count);
            end
        end
    endtask

    task automatic chk_last(input string name, input int back, input logic [3:0] req);
        int idx;
        idx = acc_q.size() - 1 - back;
        if (idx < 0) chk(name, 32'hdead, 32'(req));
        else         chk(name, 32'(acc_q[idx]), 32'(req));
    endtask

    // Directed sequence
    initial begin
        int acc_before;
        logic [2:0] seq4 [6];
        n_checks      = 0;
        n_errors      = 0;
        check_en      = 1'b0;
        rst           = 1'b1;
        tick          = 1'b0;
        bus.out_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 6; k++) m_buf[b][k] = 3'b000;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_buf", 32'(bus.out_buf), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // 1: all empty -> four scan cycles, nothing emitted
        issue_tick(0, 1'b0);
        chk("t1_count", 32'(out_count), 32'd0);
        chk("t1_no_word", 32'(acc_q.size()), 32'd0);

        // 2: single slot, then nothing more to read
        do_reset();
        set_slot(0, 0, 3'b101);
        issue_tick(0, 1'b0);
        chk_last("t2_word", 0, {2'd0, 2'b10});
        chk("t2_count", 32'(out_count), 32'd1);
        issue_tick(0, 1'b0);
        chk("t2_second_none", 32'(acc_q.size()), 32'd1);

        // 3: round robin over all four heads
        do_reset();
        clear_bufs();
        for (int b = 0; b < 4; b++) set_slot(b, 0, {2'(b), 1'b1});
        for (int i = 0; i < 4; i++) issue_tick(0, 1'b0);
        for (int i = 0; i < 4; i++) chk_last("t3_order", 3 - i, {2'(i), 2'(i)});
        chk("t3_count", 32'(out_count), 32'd4);

        // 4: pointer wrap plus re-arm by content change
        do_reset();
        clear_bufs();
        seq4[0] = 3'b101; seq4[1] = 3'b011; seq4[2] = 3'b111;
        seq4[3] = 3'b001; seq4[4] = 3'b101; seq4[5] = 3'b011;
        for (int k = 0; k < 6; k++) set_slot(1, k, seq4[k]);
        for (int i = 0; i < 6; i++) issue_tick(0, 1'b0);
        chk_last("t4_first", 5, {2'd1, 2'b10});
        chk_last("t4_sixth", 0, {2'd1, 2'b01});
        acc_before = acc_q.size();
        issue_tick(0, 1'b0);
        chk("t4_wrap_consumed", 32'(acc_q.size()), 32'(acc_before));
        set_slot(1, 0, 3'b111);
        issue_tick(0, 1'b0);
        chk_last("t4_rearm", 0, {2'd1, 2'b11});
        chk("t4_count", 32'(out_count), 32'd7);

        // 5: long backpressure with ignored ticks
        do_reset();
        clear_bufs();
        set_slot(2, 0, 3'b111);
        issue_tick(10, 1'b0);
        chk_last("t5_word", 0, {2'd2, 2'b11});
        chk("t5_count", 32'(out_count), 32'd1);

        // 6: reset while holding drops the word, slot is read again after
        do_reset();
        clear_bufs();
        set_slot(0, 0, 3'b101);
        acc_before = acc_q.size();
        issue_tick(3, 1'b1);
        chk("t6_valid_dropped", 32'(bus.out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_data_cleared", 32'(bus.out_data), 32'd0);
        chk("t6_none_accepted", 32'(acc_q.size()), 32'(acc_before));
        issue_tick(0, 1'b0);
        chk_last("t6_reemit", 0, {2'd0, 2'b10});
        chk("t6_count", 32'(out_count), 32'd1);

        // 7: counter saturation
        do_reset();
        clear_bufs();
        for (int i = 0; i < 258; i++) begin
            logic [2:0] v;
            v = m_buf[0][m_ptr[0]];
            set_slot(0, m_ptr[0], {v[2:1] + 2'd1, 1'b1});
            issue_tick(0, 1'b0);
            if (i == 253) chk("t7_count_254", 32'(out_count), 32'd254);
        end
        chk("t7_saturated", 32'(out_count), 32'd255);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
